btn_conditioner: RTL and testbench

Conditions the five raw push-button inputs (ENTER, UP, DOWN, LEFT, RIGHT) before they reach the game/menu logic feeding the VGA renderer. Each button is synchronized, debounced with a per-button counter, and turned into a clean level plus a single-cycle press pulse. An optional auto-repeat feature re-issues pulses on held direction buttons. Sits directly between the board pins and the top-level game controller, all in the pixel/system clock domain.

---
 rtl/btn_conditioner.sv | 162 ++++++++++++++++
 tb/tb_btn_conditioner.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: five-button synchronizer + debouncer with press pulses.
// Bits: 0 ENTER, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT; 1 = pressed.
// Optional feature: define BTN_AUTOREPEAT_EN to re-issue pulses on held
// direction buttons (bits 1-4); ENTER never repeats.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn_raw,
    output logic [4:0] btn_level,
    output logic [4:0] btn_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        RELEASED      = 2'd0,
        PRESS_CHECK   = 2'd1,
        PRESSED       = 2'd2,
        RELEASE_CHECK = 2'd3
    } state_e;

`ifdef BTN_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW      = $clog2(REP_MAX + 1);
`endif

    for (genvar i = 0; i < 5; i++) begin : g_bit
        logic          s1_q, s2_q;
        state_e        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          level_q, level_d;
        logic          pulse_q, pulse_d;
        logic          press_done;
        logic          rep_pulse;

        // Synchronizer, debounce FSM and output registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                state_q <= RELEASED;
                cnt_q   <= '0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                s1_q    <= btn_raw[i];
                s2_q    <= s1_q;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                pulse_q <= pulse_d;
            end
        end

        // Next-state: a level change is accepted only after DEBOUNCE_CYCLES
        // consecutive samples; the counter is cleared on every transition.
        always_comb begin
            state_d    = state_q;
            cnt_d      = cnt_q;
            press_done = 1'b0;
            case (state_q)
                RELEASED: begin
                    if (s2_q) begin
                        state_d = PRESS_CHECK;
                        cnt_d   = CW'(1);
                    end
                end
                PRESS_CHECK: begin
                    if (!s2_q) begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                        state_d    = PRESSED;
                        cnt_d      = '0;
                        press_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                PRESSED: begin
                    if (!s2_q) begin
                        state_d = RELEASE_CHECK;
                        cnt_d   = CW'(1);
                    end
                end
                RELEASE_CHECK: begin
                    if (s2_q) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end
            endcase
            level_d = (state_d == PRESSED) || (state_d == RELEASE_CHECK);
            pulse_d = press_done | rep_pulse;
        end

`ifdef BTN_AUTOREPEAT_EN
        if (i >= 1) begin : g_rep
            logic [RW-1:0] rep_q, rep_d;
            logic          first_q, first_d;

            // Repeat counter state; held (not cleared) during RELEASE_CHECK.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rep_q   <= '0;
                    first_q <= 1'b0;
                end else begin
                    rep_q   <= rep_d;
                    first_q <= first_d;
                end
            end

            // Counts only while staying in PRESSED; first interval is
            // REPEAT_DELAY, later ones REPEAT_RATE, reloading to 0 on a pulse.
            always_comb begin
                rep_d     = rep_q;
                first_d   = first_q;
                rep_pulse = 1'b0;
                if (press_done) begin
                    rep_d   = '0;
                    first_d = 1'b1;
                end else if (state_q == PRESSED && state_d == PRESSED) begin
                    if (first_q && rep_q == RW'(REPEAT_DELAY - 1)) begin
                        rep_pulse = 1'b1;
                        rep_d     = '0;
                        first_d   = 1'b0;
                    end else if (!first_q && rep_q == RW'(REPEAT_RATE - 1)) begin
                        rep_pulse = 1'b1;
                        rep_d     = '0;
                    end else begin
                        rep_d = rep_q + RW'(1);
                    end
                end
            end
        end else begin : g_norep
            assign rep_pulse = 1'b0;
        end
`else
        assign rep_pulse = 1'b0;
`endif

        assign btn_level[i] = level_q;
        assign btn_pulse[i] = pulse_q;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4
// (and REPEAT_DELAY=20, REPEAT_RATE=8 when BTN_AUTOREPEAT_EN is defined).
module tb_btn_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] btn_pulse;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    btn_conditioner #(
        .DEBOUNCE_CYCLES(4)
`ifdef BTN_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY(20),
        .REPEAT_RATE(8)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse)
    );

    // Clock
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [4:0] e;

        // Reset held with every button pressed
        rst     = 1'b1;
        btn_raw = 5'b11111;
        for (int k = 0; k < 3; k++) begin
            step();
            check("rst_level", btn_level, 5'b00000);
            check("rst_pulse", btn_pulse, 5'b00000);
        end
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            check("post_rst_pulse", btn_pulse, (k == 6) ? 5'b11111 : 5'b00000);
            check("post_rst_level", btn_level, (k >= 6) ? 5'b11111 : 5'b00000);
        end

        // Release all: level falls 6 edges later, no release pulse
        btn_raw = 5'b00000;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("rel_all_level", btn_level, (k >= 6) ? 5'b00000 : 5'b11111);
            check("rel_all_pulse", btn_pulse, 5'b00000);
        end

        // Clean press on UP, held 30 cycles
        btn_raw = 5'b00010;
        for (int k = 1; k <= 30; k++) begin
            step();
            e = 5'b00000;
            if (k == 6 || (AR && k == 26)) e = 5'b00010;
            check("up_pulse", btn_pulse, e);
            check("up_level", btn_level, (k >= 6) ? 5'b00010 : 5'b00000);
        end
        btn_raw = 5'b00000;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("up_rel_level", btn_level, (k >= 6) ? 5'b00000 : 5'b00010);
            check("up_rel_pulse", btn_pulse, 5'b00000);
        end

        // Bounce on LEFT: 1,0,1,1,0,1 then low
        begin
            logic [5:0] pat;
            pat = 6'b101101;
            for (int k = 0; k < 16; k++) begin
                btn_raw = (k < 6) ? {1'b0, pat[5-k], 3'b000} : 5'b00000;
                step();
                check("bounce_pulse", btn_pulse, 5'b00000);
                check("bounce_level", btn_level, 5'b00000);
            end
        end

        // ENTER held with a 2-cycle low glitch
        btn_raw = 5'b00001;
        for (int k = 1; k <= 10; k++) begin
            step();
            check("ent_pulse", btn_pulse, (k == 6) ? 5'b00001 : 5'b00000);
        end
        btn_raw = 5'b00000;
        step();
        check("glitch_level", btn_level, 5'b00001);
        step();
        check("glitch_level", btn_level, 5'b00001);
        btn_raw = 5'b00001;
        for (int k = 1; k <= 12; k++) begin
            step();
            check("glitch_level", btn_level, 5'b00001);
            check("glitch_pulse", btn_pulse, 5'b00000);
        end
        btn_raw = 5'b00000;
        for (int k = 1; k <= 8; k++) step();
        check("ent_rel_level", btn_level, 5'b00000);

        // RIGHT and ENTER held 60 cycles (repeats only on RIGHT when enabled)
        btn_raw = 5'b10001;
        for (int k = 1; k <= 60; k++) begin
            step();
            e = 5'b00000;
            if (k == 6) e = 5'b10001;
            if (AR && k >= 26 && ((k - 26) % 8) == 0) e[4] = 1'b1;
            check("rep_pulse", btn_pulse, e);
        end
        btn_raw = 5'b00000;
        for (int k = 1; k <= 10; k++) begin
            step();
            check("rep_rel_pulse", btn_pulse, 5'b00000);
        end
        check("rep_rel_level", btn_level, 5'b00000);

        // Reset mid-hold on DOWN
        btn_raw = 5'b00100;
        for (int k = 1; k <= 16; k++) begin
            step();
            check("down_pulse", btn_pulse, (k == 6) ? 5'b00100 : 5'b00000);
        end
        rst = 1'b1;
        step();
        check("midrst_level", btn_level, 5'b00000);
        check("midrst_pulse", btn_pulse, 5'b00000);
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            check("re_press_pulse", btn_pulse, (k == 6) ? 5'b00100 : 5'b00000);
            check("re_press_level", btn_level, (k >= 6) ? 5'b00100 : 5'b00000);
        end
        btn_raw = 5'b00000;
        for (int k = 1; k <= 8; k++) step();
        check("down_rel_level", btn_level, 5'b00000);

        // Press shorter than the debounce window on LEFT
        btn_raw = 5'b01000;
        for (int k = 1; k <= 3; k++) step();
        btn_raw = 5'b00000;
        for (int k = 1; k <= 10; k++) begin
            step();
            check("short_pulse", btn_pulse, 5'b00000);
            check("short_level", btn_level, 5'b00000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
